// File: rtl/uart_msg_sender_pkg.sv
// Shared definitions for the multiplayer UART message sender and decoder:
// protocol byte values and the sender FSM state encoding.
package uart_msg_sender_pkg;

  localparam logic [7:0] MSG_LOST  = 8'h4C;
  localparam logic [7:0] MSG_HIT   = 8'h48;
  localparam logic [7:0] MSG_READY = 8'h52;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } snd_state_e;

endpackage

// File: rtl/uart_msg_queue.sv
// Pending-event store for the message sender: lost/ready flags, a saturating
// hit counter, fixed-priority selection (lost > hit > ready) and dequeue.
module uart_msg_queue
  import uart_msg_sender_pkg::*;
#(
  parameter int HIT_CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       lost_i,
  input  logic       hit_i,
  input  logic       ready_i,
  input  logic       deq_i,
  output logic       pend_o,
  output logic       pend_d_o,
  output logic [7:0] sel_o
);

  logic                 lost_q, lost_d;
  logic                 ready_q, ready_d;
  logic [HIT_CNT_W-1:0] hit_q, hit_d;
  logic [HIT_CNT_W:0]   hit_sum;
  logic [HIT_CNT_W-1:0] hit_sat;
  logic                 hit_any;
  logic                 deq_lost, deq_hit, deq_ready;

  always_comb begin
    hit_any   = |hit_q;
    pend_o    = lost_q | hit_any | ready_q;
    sel_o     = lost_q ? MSG_LOST : (hit_any ? MSG_HIT : MSG_READY);
    deq_lost  = deq_i & lost_q;
    deq_hit   = deq_i & ~lost_q & hit_any;
    deq_ready = deq_i & ~lost_q & ~hit_any & ready_q;

    // Carry bit of the widened sum flags a hit arriving at saturation.
    hit_sum = {1'b0, hit_q} + {{HIT_CNT_W{1'b0}}, hit_i} - {{HIT_CNT_W{1'b0}}, deq_hit};
    hit_sat = hit_sum[HIT_CNT_W] ? '1 : hit_sum[HIT_CNT_W-1:0];

    lost_d  = (lost_q & ~deq_lost) | lost_i;
    ready_d = (ready_q & ~deq_ready & ~deq_lost) | ready_i;
    hit_d   = deq_lost ? HIT_CNT_W'(hit_i) : hit_sat;

    if (!en_i) begin
      lost_d  = 1'b0;
      ready_d = 1'b0;
      hit_d   = '0;
    end
    pend_d_o = lost_d | (|hit_d) | ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q  <= 1'b0;
      ready_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      lost_q  <= lost_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: rtl/uart_msg_sender.sv
// Turns local game events into one-byte UART messages with an inter-frame gap.
// Optional WAIT_DONE watchdog enabled by defining UART_MSG_SENDER_TIMEOUT_EN.
module uart_msg_sender
  import uart_msg_sender_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int HIT_CNT_W      = 3,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       multiplayer,
  input  logic       player_lost,
  input  logic       player_hit,
  input  logic       player_ready,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       tx_error
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  snd_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, busy_q;
  logic          deq, pend, pend_d;
  logic [7:0]    sel;

  uart_msg_queue #(.HIT_CNT_W(HIT_CNT_W)) u_queue (
    .clk      (clk),
    .rst_n    (rst),
    .en_i     (multiplayer),
    .lost_i   (player_lost),
    .hit_i    (player_hit),
    .ready_i  (player_ready),
    .deq_i    (deq),
    .pend_o   (pend),
    .pend_d_o (pend_d),
    .sel_o    (sel)
  );

`ifdef UART_MSG_SENDER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout, err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    deq     = 1'b0;
`ifdef UART_MSG_SENDER_TIMEOUT_EN
    wd_d    = wd_q;
    timeout = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (multiplayer && pend) begin
          deq     = 1'b1;
          data_d  = sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_DONE;
`ifdef UART_MSG_SENDER_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT_DONE: begin
        // A done tick in the same cycle as the timeout takes precedence.
        if (tx_done_tick) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GW'(GAP_CYCLES - 1);
            state_d = GAP;
          end
        end
`ifdef UART_MSG_SENDER_TIMEOUT_EN
        else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      start_q <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE) | pend_d;
    end
  end

`ifdef UART_MSG_SENDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= timeout;
    end
  end
  assign tx_error = err_q;
`else
  assign tx_error = 1'b0;
`endif

  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Bench for uart_msg_sender: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_msg_sender;

  localparam int G    = 16;
  localparam int HW   = 3;
  localparam int TO   = 50;
  localparam int HMAX = (1 << HW) - 1;

  logic       clk = 1'b0, rst = 1'b0, mp = 1'b0;
  logic       pl = 1'b0, ph = 1'b0, pr = 1'b0, done = 1'b0;
  logic       tx_start, busy, tx_error;
  logic [7:0] tx_data;

  uart_msg_sender #(.GAP_CYCLES(G), .HIT_CNT_W(HW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .multiplayer(mp), .player_lost(pl), .player_hit(ph),
    .player_ready(pr), .tx_done_tick(done), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [7:0] sent[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending counts, one open frame, earliest allowed dequeue edge.
  typedef struct {
    int         cyc, l, h, r, deq_edge, allowed;
    bit         open;
    logic       start, err, busy;
    logic [7:0] data;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.cyc = 0; n.l = 0; n.h = 0; n.r = 0; n.deq_edge = 0; n.allowed = 0;
    n.open = 0; n.start = 0; n.err = 0; n.busy = 0; n.data = 8'h00;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t s, bit en, bit lost, bit hit, bit rdy, bit dn);
    mdl_t n = s;
    int c = s.cyc + 1;
    bit wt, take;
    n.cyc = c; n.start = 0; n.err = 0;
    wt = s.open && (c >= s.deq_edge + 2);
    if (wt && dn) begin
      n.open = 0; n.allowed = c + 1 + G;
    end
`ifdef UART_MSG_SENDER_TIMEOUT_EN
    else if (wt && (c - s.deq_edge - 1) == TO) begin
      n.open = 0; n.allowed = c + 1; n.err = 1;
    end
`endif
    take = en && !s.open && (c >= s.allowed) && (s.l != 0 || s.h > 0 || s.r != 0);
    if (take) begin
      n.open = 1; n.deq_edge = c; n.start = 1;
      if (s.l != 0)    begin n.data = 8'h4C; n.l = 0; n.h = 0; n.r = 0; end
      else if (s.h > 0) begin n.data = 8'h48; n.h = s.h - 1; end
      else             begin n.data = 8'h52; n.r = 0; end
    end
    if (lost) n.l = 1;
    if (hit)  n.h = (n.h + 1 > HMAX) ? HMAX : n.h + 1;
    if (rdy)  n.r = 1;
    if (!en) begin n.l = 0; n.h = 0; n.r = 0; end
    n.busy = n.open || (c + 1 < n.allowed) || n.l != 0 || n.h > 0 || n.r != 0;
    return n;
  endfunction

  mdl_t m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= mdl_reset();
    else      m <= step(m, mp, pl, ph, pr, done);
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("tx_start", tx_start, m.start);
      chk("tx_data", tx_data, m.data);
      chk("busy", busy, m.busy);
      chk("tx_error", tx_error, m.err);
      if (tx_start) sent.push_back(tx_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit l, input bit h, input bit r);
    pl = l; ph = h; pr = r;
    tick(1);
    pl = 0; ph = 0; pr = 0;
  endtask

  task automatic respond(input int lat);
    repeat (lat) @(posedge clk);
    #1 done = 1;
    tick(1);
    done = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!tx_start && n < 60) begin @(negedge clk); n++; end
    chk("wait_start", tx_start, 1);
  endtask

  task automatic serve_all(input int lat);
    int k = 0;
    while (k < 30) begin
      int n = 0;
      while (!tx_start && busy && n < 300) begin @(negedge clk); n++; end
      if (!tx_start) break;
      respond(lat);
      k++;
    end
    chk("serve_all_idle", busy, 0);
  endtask

  initial begin
    int n;
    int hits;
    // Reset: outputs low even with events asserted
    rst = 0; mp = 1; ph = 1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_tx_error", tx_error, 0);
    ph = 0;
    @(posedge clk); #1 rst = 1;
    tick(2);

    // Single ready: start 2 clocks after event, then G gap cycles
    sent.delete();
    pulse(0, 0, 1);
    @(negedge clk); chk("t1_start_early", tx_start, 0);
    @(negedge clk); chk("t1_start", tx_start, 1); chk("t1_data", tx_data, 8'h52);
    respond(3);
    n = 0;
    while (n < 100) begin @(negedge clk); if (!busy) break; n++; end
    chk("t1_gap_busy", n, G);

    // Simultaneous hit + ready: 'H' then 'R', exactly G idle clocks between
    sent.delete();
    pulse(0, 1, 1);
    wait_start();
    respond(2);
    n = 0;
    while (!tx_start && n < 40) begin @(negedge clk); n++; end
    chk("t2_gap_to_start", n, G + 2);
    respond(2);
    serve_all(2);
    chk("t2_count", sent.size(), 2);
    if (sent.size() == 2) begin
      chk("t2_first", sent[0], 8'h48);
      chk("t2_second", sent[1], 8'h52);
    end

    // Hit burst: 1 + 8 hits, counter saturates at 7 -> 8 frames
    sent.delete();
    pulse(0, 1, 0);
    wait_start();
    ph = 1; tick(8); ph = 0;
    respond(2);
    serve_all(2);
    hits = 0;
    foreach (sent[i]) if (sent[i] == 8'h48) hits++;
    chk("t3_count", sent.size(), 8);
    chk("t3_hits", hits, 8);

    // Lost during WAIT_DONE flushes queued hits and ready
    sent.delete();
    pulse(0, 0, 1);
    wait_start();
    ph = 1; tick(3); ph = 0;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    respond(2);
    serve_all(2);
    chk("t4_count", sent.size(), 2);
    if (sent.size() == 2) chk("t4_last", sent[1], 8'h4C);

    // Multiplayer gating and a stray done tick while idle
    sent.delete();
    mp = 0;
    pulse(1, 1, 1);
    done = 1; tick(1); done = 0;
    tick(10);
    chk("t5_none_sent", sent.size(), 0);
    chk("t5_idle", busy, 0);
    mp = 1;
    pulse(0, 1, 1);
    wait_start();
    pulse(0, 1, 0);
    mp = 0;
    respond(2);
    serve_all(2);
    tick(30);
    chk("t5_one_frame", sent.size(), 1);
    if (sent.size() == 1) chk("t5_frame", sent[0], 8'h48);
    mp = 1;

`ifdef UART_MSG_SENDER_TIMEOUT_EN
    // Watchdog: no done -> error on the 50th WAIT_DONE cycle, no gap
    sent.delete();
    pulse(0, 0, 1);
    wait_start();
    n = 0;
    while (!tx_error && n < 100) begin @(negedge clk); n++; end
    chk("t6_timeout_cycle", n, TO + 1);
    chk("t6_idle_after", busy, 0);
    // Done on the timeout cycle wins
    pulse(0, 0, 1);
    wait_start();
    repeat (TO) @(posedge clk);
    #1 done = 1;
    tick(1);
    done = 0;
    n = 0;
    repeat (5) begin @(negedge clk); if (tx_error) n++; end
    chk("t6_done_wins", n, 0);
    serve_all(2);
`endif

    tick(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_sender.md
Name: uart_msg_sender

Overview:
Transmit-side counterpart of the multiplayer UART message decoder. Converts local game events into single-byte protocol messages for the UART transmitter:
- 'L' (8'h4C): local player lost, so the opponent wins.
- 'H' (8'h48): local player was hit.
- 'R' (8'h52): local player is ready.

It queues events, sends them one at a time with a fixed priority, waits for the transmitter's done tick, and enforces an inter-frame gap. Active only in multiplayer mode.

Parameters:
- GAP_CYCLES, 16: idle clocks inserted after each tx_done_tick before the next tx_start; 0 means no gap.
- HIT_CNT_W, 3: width of the pending-hit counter, which saturates at 2^HIT_CNT_W-1.
- TIMEOUT_CYCLES, 200000: watchdog limit in WAIT_DONE; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- multiplayer  in  1  enables the block; when 0, events are ignored and the queue is flushed
- player_lost  in  1  single-cycle pulse: local defeat, send 'L'
- player_hit  in  1  single-cycle pulse: local hit, send 'H'
- player_ready  in  1  single-cycle pulse: local ready, send 'R'
- tx_done_tick  in  1  single-cycle pulse from the UART transmitter when a frame completes
- tx_start  out  1  single-cycle pulse requesting transmission of tx_data
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done_tick
- busy  out  1  high in any state other than IDLE, or while anything is pending
- tx_error  out  1  single-cycle pulse on watchdog abort; constant 0 without the optional feature

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all pending flags, the hit counter and all timers cleared.
  - tx_start=0, tx_data=8'h00, busy=0, tx_error=0.
  - All outputs are registered.
- Pending store: lost_pend (flag), hit_cnt (HIT_CNT_W bits), ready_pend (flag).
  - An event input high with multiplayer=1 sets its flag or increments hit_cnt at the next edge.
  - A hit that arrives while hit_cnt is saturated is dropped.
  - Same-cycle increment and decrement of hit_cnt: next = cnt + inc - dec, saturated. Net effect is unchanged when both occur.
  - A set of ready_pend and a clear of ready_pend in the same cycle resolve to set, so the new request survives.
- multiplayer=0: all pending state is cleared every cycle and events are ignored. A frame already in LOAD or WAIT_DONE completes normally (the transmitter is not aborted), then the FSM returns to IDLE.
- Priority when selecting the next message: lost > hit > ready.
  - Loading 'L' also clears hit_cnt and ready_pend, since the game is over.
- FSM states:
  - IDLE: if any item is pending and multiplayer=1, latch the selected byte into tx_data, dequeue it, and go to LOAD.
  - LOAD: tx_start=1 for exactly this one cycle, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_done_tick. If GAP_CYCLES=0, go to IDLE; otherwise load the gap counter and go to GAP.
  - GAP: count down to 0, then go to IDLE.
- Latency:
  - An event pulse at edge N sets the pending item at N+1; IDLE dequeues at N+1; tx_start is high during cycle N+2.
  - An event arriving while the FSM is busy waits in the queue.
- A tx_done_tick outside WAIT_DONE is ignored.
- A reset asserted mid-frame aborts immediately. The transmitter is expected to be reset by the same rst.

Optional Feature:
- Macro UART_MSG_SENDER_TIMEOUT_EN.
- When defined: a 32-bit watchdog counts cycles in WAIT_DONE. When it reaches TIMEOUT_CYCLES with no tx_done_tick:
  - tx_error pulses for 1 cycle and the FSM goes to IDLE, skipping GAP.
  - The aborted byte is not re-queued.
  - If tx_done_tick and the timeout occur in the same cycle, done wins and there is no error.
- When undefined: no watchdog logic is built, tx_error is tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package (used by both the decoder and this block):
  - message byte constants MSG_LOST=8'h4C, MSG_HIT=8'h48, MSG_READY=8'h52;
  - the sender state encoding IDLE/LOAD/WAIT_DONE/GAP (2 bits).
- One natural sub-module: uart_msg_queue. It holds the pending flags, the saturating hit counter, the priority select and the dequeue logic. The parent holds the FSM and the timers.

Test Plan:
- Reset and single ready: rst=0, then release; pulse player_ready with multiplayer=1 → tx_start one cycle at +2 clocks, tx_data=8'h52; tx_done_tick → GAP_CYCLES idle cycles, then busy=0.
- Simultaneous events: pulse player_hit and player_ready in the same cycle → frames 8'h48 then 8'h52, with a gap of at least GAP_CYCLES between tx_done_tick and the next tx_start.
- Hit burst and saturation: 9 player_hit pulses while the first frame is outstanding, HIT_CNT_W=3 → exactly 8 frames of 8'h48; the extra hit is dropped.
- Lost flushes the queue: queue 3 hits plus ready, then pulse player_lost during WAIT_DONE → the next and only remaining frame is 8'h4C.
- Multiplayer gating: multiplayer=0 with all three events pulsed → no tx_start; drop multiplayer mid-WAIT_DONE with pending items → the current frame finishes and nothing further is sent.
- Timeout (macro defined, TIMEOUT_CYCLES=50): withhold tx_done_tick → tx_error pulses at cycle 50 of WAIT_DONE and the FSM returns to IDLE; done and timeout in the same cycle → no tx_error.
